// File: rtl/prog_loader_if.sv
// Byte-stream handshake between the host byte source (master) and the loader (slave).
interface prog_loader_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Program-memory loader: takes a length-prefixed, checksummed byte frame and writes the
// data bytes into program memory while holding the CPU in reset.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no session since reset, waiting for start
//   LEN_HI | expecting length high byte (low nibble = N[11:8])
//   LEN_LO | expecting length low byte (N[7:0])
//   DATA   | writing data bytes, remaining_q counts down to 1
//   CSUM   | expecting checksum byte
//   DONE   | frame sums to zero, CPU released
//   ERR    | frame checksum bad, CPU stays held
module prog_loader #(
  parameter int                 ADDR_W    = 12,
  parameter int                 DATA_W    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  prog_loader_if.slave      in_if,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] bytes_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q;
  logic [3:0]        len_hi_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [ADDR_W-1:0] bytes_loaded_q;
  logic [DATA_W-1:0] csum_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              error_q;

  logic              in_ready;
  logic              xfer;
  logic [DATA_W-1:0] csum_d;
  logic [ADDR_W-1:0] len_d;

  // Ready depends on state alone so the source may wait on it before raising valid.
  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);

  always_comb begin
    xfer   = in_if.in_valid & in_ready;
    csum_d = csum_q + in_if.in_data;
    len_d  = ADDR_W'({len_hi_q, in_if.in_data});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      len_hi_q       <= '0;
      remaining_q    <= '0;
      bytes_loaded_q <= '0;
      csum_q         <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (xfer) csum_q <= csum_d;

      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q        <= S_LEN_HI;
            csum_q         <= '0;
            bytes_loaded_q <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_hold_q     <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= in_if.in_data[3:0];
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            remaining_q <= len_d;
            state_q     <= (len_d == '0) ? S_CSUM : S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_we_q       <= 1'b1;
            mem_addr_q     <= BASE_ADDR + bytes_loaded_q;
            mem_wdata_q    <= in_if.in_data;
            bytes_loaded_q <= bytes_loaded_q + 1'b1;
            remaining_q    <= remaining_q - 1'b1;
            if (remaining_q == ADDR_W'(1)) state_q <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (csum_d == '0) begin
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              state_q    <= S_DONE;
            end else begin
              error_q <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_if.in_ready = in_ready;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign cpu_hold_o     = cpu_hold_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign bytes_loaded_o = bytes_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 000 and FFE) share one stimulus stream and
// are compared every cycle against a frame-position model, plus literal spot checks.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tb_start = 1'b0;
  logic        tb_valid = 1'b0;
  logic [7:0]  tb_data = 8'h00;

  always #5 clk = ~clk;

  prog_loader_if if0 ();
  prog_loader_if if1 ();
  assign if0.in_valid = tb_valid;
  assign if0.in_data  = tb_data;
  assign if1.in_valid = tb_valid;
  assign if1.in_data  = tb_data;

  logic        we0, we1, hold0, hold1, done0, done1, err0, err1;
  logic [11:0] addr0, addr1, bytes0, bytes1;
  logic [7:0]  wd0, wd1;

  prog_loader #(.ADDR_W(12), .DATA_W(8), .BASE_ADDR(12'h000)) dut0 (
    .clk(clk), .reset(reset), .start_i(tb_start), .in_if(if0),
    .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wd0), .cpu_hold_o(hold0),
    .done_o(done0), .error_o(err0), .bytes_loaded_o(bytes0));

  prog_loader #(.ADDR_W(12), .DATA_W(8), .BASE_ADDR(12'hFFE)) dut1 (
    .clk(clk), .reset(reset), .start_i(tb_start), .in_if(if1),
    .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wd1), .cpu_hold_o(hold1),
    .done_o(done1), .error_o(err1), .bytes_loaded_o(bytes1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position within the frame decides what each accepted byte means.
  int m_recv, m_pos, m_n, m_nhi, m_sum, m_bytes;
  int m_we, m_addr0, m_addr1, m_wdata, m_done, m_err, m_hold;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_recv = 0; m_pos = 0; m_n = 0; m_nhi = 0; m_sum = 0; m_bytes = 0;
      m_we = 0; m_addr0 = 0; m_addr1 = 0; m_wdata = 0; m_done = 0; m_err = 0; m_hold = 0;
    end else begin
      m_we = 0;
      if (m_recv != 0 && tb_valid) begin
        m_sum = (m_sum + int'(tb_data)) % 256;
        if (m_pos == 0) m_nhi = int'(tb_data) % 16;
        else if (m_pos == 1) m_n = m_nhi * 256 + int'(tb_data);
        else if (m_pos < m_n + 2) begin
          m_we = 1;
          m_addr0 = m_bytes % 4096;
          m_addr1 = (4094 + m_bytes) % 4096;
          m_wdata = int'(tb_data);
          m_bytes++;
        end else begin
          m_recv = 0;
          if (m_sum == 0) begin m_done = 1; m_hold = 0; end
          else m_err = 1;
        end
        m_pos++;
      end else if (m_recv == 0 && tb_start) begin
        m_recv = 1; m_pos = 0; m_sum = 0; m_bytes = 0;
        m_done = 0; m_err = 0; m_hold = 1;
      end
    end
  end

  logic [11:0] log_a0[$], log_a1[$];
  logic [7:0]  log_d0[$];

  always @(negedge clk) begin
    chk("in_ready0", 32'(if0.in_ready), m_recv);
    chk("in_ready1", 32'(if1.in_ready), m_recv);
    chk("mem_we0", 32'(we0), m_we);
    chk("mem_we1", 32'(we1), m_we);
    chk("mem_addr0", 32'(addr0), m_addr0);
    chk("mem_addr1", 32'(addr1), m_addr1);
    chk("mem_wdata0", 32'(wd0), m_wdata);
    chk("mem_wdata1", 32'(wd1), m_wdata);
    chk("bytes_loaded0", 32'(bytes0), m_bytes);
    chk("bytes_loaded1", 32'(bytes1), m_bytes);
    chk("done0", 32'(done0), m_done);
    chk("error0", 32'(err0), m_err);
    chk("cpu_hold0", 32'(hold0), m_hold);
    chk("cpu_hold1", 32'(hold1), m_hold);
    if (we0 === 1'b1) begin log_a0.push_back(addr0); log_d0.push_back(wd0); end
    if (we1 === 1'b1) log_a1.push_back(addr1);
  end

  logic [7:0] frame[$];

  task automatic pulse_start();
    @(negedge clk); tb_valid = 1'b0; tb_start = 1'b1;
    @(negedge clk); tb_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      tb_valid = 1'b1;
      tb_data  = d;
      if (if0.in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    chk("in_ready_wait", 32'(ok), 1);
  endtask

  task automatic go_idle();
    @(negedge clk); tb_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < frame.size(); i++) begin
      if (gap_max > 0 && i > 1) begin
        int g;
        g = $urandom_range(gap_max, 0);
        for (int k = 0; k < g; k++) begin @(negedge clk); tb_valid = 1'b0; end
      end
      send_byte(frame[i]);
    end
    go_idle();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(if0.in_ready), 0);
    chk("reset_hold", 32'(hold0), 0);
    chk("reset_addr", 32'(addr0), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 03+A1+B2+C3 = 0x219 -> checksum byte E7 closes the frame to zero.
    log_a0.delete(); log_a1.delete(); log_d0.delete();
    pulse_start();
    frame = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE7};
    send_frame(0);
    chk("t1_done", 32'(done0), 1);
    chk("t1_error", 32'(err0), 0);
    chk("t1_hold", 32'(hold0), 0);
    chk("t1_bytes", 32'(bytes0), 3);
    chk("t1_nwr", log_a0.size(), 3);
    if (log_a0.size() == 3) begin
      chk("t1_a0", 32'(log_a0[0]), 32'h000); chk("t1_d0", 32'(log_d0[0]), 32'hA1);
      chk("t1_a1", 32'(log_a0[1]), 32'h001); chk("t1_d1", 32'(log_d0[1]), 32'hB2);
      chk("t1_a2", 32'(log_a0[2]), 32'h002); chk("t1_d2", 32'(log_d0[2]), 32'hC3);
    end
    chk("t4_nwr", log_a1.size(), 3);
    if (log_a1.size() == 3) begin
      chk("t4_a0", 32'(log_a1[0]), 32'hFFE);
      chk("t4_a1", 32'(log_a1[1]), 32'hFFF);
      chk("t4_a2", 32'(log_a1[2]), 32'h000);
    end
    repeat (2) @(negedge clk);

    pulse_start();
    frame = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE8};
    send_frame(0);
    chk("t2_error", 32'(err0), 1);
    chk("t2_done", 32'(done0), 0);
    chk("t2_hold", 32'(hold0), 1);
    pulse_start();
    chk("t2_restart_ready", 32'(if0.in_ready), 1);
    chk("t2_restart_error", 32'(err0), 0);

    log_a0.delete(); log_a1.delete(); log_d0.delete();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    chk("t3_done", 32'(done0), 1);
    chk("t3_bytes", 32'(bytes0), 0);
    chk("t3_nwr", log_a0.size(), 0);

    // 04+11+22+33+44 = 0xAE -> checksum 52; random valid gaps plus an ignored start.
    log_a0.delete(); log_a1.delete(); log_d0.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h11);
    pulse_start();
    frame = '{8'h22, 8'h33, 8'h44, 8'h52};
    for (int i = 0; i < frame.size(); i++) begin
      int g;
      g = $urandom_range(3, 0);
      for (int k = 0; k < g; k++) begin @(negedge clk); tb_valid = 1'b0; end
      send_byte(frame[i]);
    end
    go_idle();
    chk("t5_done", 32'(done0), 1);
    chk("t5_nwr", log_d0.size(), 4);
    if (log_d0.size() == 4) begin
      chk("t5_d3", 32'(log_d0[3]), 32'h44);
      chk("t5_a3", 32'(log_a0[3]), 32'h003);
      chk("t5_wrap_a3", 32'(log_a1[3]), 32'h001);
    end

    log_a0.delete(); log_a1.delete(); log_d0.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h05); send_byte(8'hD0); send_byte(8'hD1);
    go_idle();
    #2 reset = 1'b1;
    #1;
    chk("t6_we", 32'(we0), 0);
    chk("t6_ready", 32'(if0.in_ready), 0);
    chk("t6_hold", 32'(hold0), 0);
    chk("t6_bytes", 32'(bytes0), 0);
    chk("t6_addr", 32'(addr0), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_nwr", log_a0.size(), 2);
    chk("t6_idle_ready", 32'(if0.in_ready), 0);
    // 01+5A = 0x5B -> checksum A5.
    log_a0.delete(); log_a1.delete(); log_d0.delete();
    pulse_start();
    frame = '{8'h00, 8'h01, 8'h5A, 8'hA5};
    send_frame(0);
    chk("t6_new_done", 32'(done0), 1);
    chk("t6_new_nwr", log_a0.size(), 1);
    if (log_a0.size() == 1) chk("t6_new_a0", 32'(log_a0[0]), 32'h000);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
